id_ex_hazard_stage: RTL

- ID→EX pipeline register with an integrated load-use interlock for the 5-stage MIPS-DLX pipeline.
- Captures decoded operands, register specifiers and control from ID, and presents rs/rt/rw and control to the EX stage and the forwarding unit.
- Detects load-use hazards that forwarding cannot resolve. Stalls PC and IF/ID for one cycle and injects a bubble into EX.
- Also inserts bubbles on branch flush.

---
 rtl/mips_pkg.sv | 33 +++
 rtl/load_use_detector.sv | 17 +
 rtl/id_ex_hazard_stage.sv | 106 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared widths, register/ALU encodings and the bubble control word for the
// MIPS-DLX pipeline.
package mips_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam int ALUOP_W = 4;

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALUOP_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 4'd3;
    localparam logic [ALUOP_W-1:0] ALU_XOR = 4'd4;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 4'd5;
    localparam logic [ALUOP_W-1:0] ALU_SLL = 4'd6;
    localparam logic [ALUOP_W-1:0] ALU_SRL = 4'd7;

    typedef struct packed {
        logic                mem_read;
        logic                mem_write;
        logic                write_reg;
        logic                mem_to_reg;
        logic                alu_src;
        logic [ALUOP_W-1:0]  alu_op;
    } ctrl_t;

    // A bubble does nothing: no register write, no memory access, ALU_ADD.
    localparam ctrl_t BUBBLE = '{mem_read: 1'b0, mem_write: 1'b0, write_reg: 1'b0,
                                 mem_to_reg: 1'b0, alu_src: 1'b0, alu_op: ALU_ADD};

endpackage

// File: rtl/load_use_detector.sv
// Load-use hazard: the load in EX writes a register the ID instruction reads.
module load_use_detector
    import mips_pkg::*;
(
    input  logic             mem_read_EX,
    input  logic [REG_W-1:0] rw_EX,
    input  logic [REG_W-1:0] rs_ID,
    input  logic [REG_W-1:0] rt_ID,
    input  logic             uses_rt_ID,
    output logic             hazard
);

    // $zero is never a real dependency.
    assign hazard = mem_read_EX && (rw_EX != ZERO_REG) &&
                    ((rw_EX == rs_ID) || (uses_rt_ID && (rw_EX == rt_ID)));

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use interlock and branch-flush bubbles.
// Optional stall cycle counter built only when STALL_COUNT_EN is defined.
module id_ex_hazard_stage
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic [REG_W-1:0]   rs_ID,
    input  logic [REG_W-1:0]   rt_ID,
    input  logic [REG_W-1:0]   rd_ID,
    input  logic               reg_dst_ID,
    input  logic               uses_rt_ID,
    input  logic [DATA_W-1:0]  read_data1_ID,
    input  logic [DATA_W-1:0]  read_data2_ID,
    input  logic [DATA_W-1:0]  imm_ID,
    input  logic               mem_read_ID,
    input  logic               mem_write_ID,
    input  logic               write_reg_ID,
    input  logic               mem_to_reg_ID,
    input  logic               alu_src_ID,
    input  logic [ALUOP_W-1:0] alu_op_ID,
    output logic [REG_W-1:0]   rs_EX,
    output logic [REG_W-1:0]   rt_EX,
    output logic [REG_W-1:0]   rw_EX,
    output logic [DATA_W-1:0]  read_data1_EX,
    output logic [DATA_W-1:0]  read_data2_EX,
    output logic [DATA_W-1:0]  imm_EX,
    output logic               mem_read_EX,
    output logic               mem_write_EX,
    output logic               write_reg_EX,
    output logic               mem_to_reg_EX,
    output logic               alu_src_EX,
    output logic [ALUOP_W-1:0] alu_op_EX,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               stall,
    output logic [31:0]        stall_count
);

    logic  hazard;
    ctrl_t ctrl_ID;
    ctrl_t ctrl_q;

    load_use_detector u_load_use_detector (
        .mem_read_EX (ctrl_q.mem_read),
        .rw_EX       (rw_EX),
        .rs_ID       (rs_ID),
        .rt_ID       (rt_ID),
        .uses_rt_ID  (uses_rt_ID),
        .hazard      (hazard)
    );

    // A taken branch discards the ID instruction, so it must not also stall.
    assign stall      = hazard && !flush;
    assign pc_write   = !stall;
    assign ifid_write = !stall;

    assign ctrl_ID = '{mem_read: mem_read_ID, mem_write: mem_write_ID,
                       write_reg: write_reg_ID, mem_to_reg: mem_to_reg_ID,
                       alu_src: alu_src_ID, alu_op: alu_op_ID};

    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush || stall) begin
            ctrl_q        <= BUBBLE;
            rs_EX         <= ZERO_REG;
            rt_EX         <= ZERO_REG;
            rw_EX         <= ZERO_REG;
            read_data1_EX <= '0;
            read_data2_EX <= '0;
            imm_EX        <= '0;
        end else begin
            ctrl_q        <= ctrl_ID;
            rs_EX         <= rs_ID;
            rt_EX         <= rt_ID;
            rw_EX         <= reg_dst_ID ? rd_ID : rt_ID;
            read_data1_EX <= read_data1_ID;
            read_data2_EX <= read_data2_ID;
            imm_EX        <= imm_ID;
        end
    end

    assign mem_read_EX   = ctrl_q.mem_read;
    assign mem_write_EX  = ctrl_q.mem_write;
    assign write_reg_EX  = ctrl_q.write_reg;
    assign mem_to_reg_EX = ctrl_q.mem_to_reg;
    assign alu_src_EX    = ctrl_q.alu_src;
    assign alu_op_EX     = ctrl_q.alu_op;

`ifdef STALL_COUNT_EN
    logic [31:0] stall_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_q <= '0;
        end else if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = '0;
`endif

endmodule
